// File: rtl/mram_burst_read_ctrl_if.sv
// Host, MRAM and serializer signal bundle for the MRAM burst read sequencer.
interface mram_burst_read_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] start_addr;
    logic [7:0]        burst_len;
    logic [1:0]        word_sel;
    logic [15:0]       mram_data_in;
    logic              mram_ce;
    logic              mram_oe;
    logic [ADDR_W-1:0] mram_addr;
    logic              ser_en;
    logic              ser_load;
    logic              ser_send_data;
    logic [1:0]        ser_word_sel;
    logic [15:0]       ser_data;
    logic              bit_valid;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, abort, start_addr, burst_len, word_sel, mram_data_in,
        input  mram_ce, mram_oe, mram_addr, ser_en, ser_load, ser_send_data,
               ser_word_sel, ser_data, bit_valid, busy, done, err
    );

    modport slave (
        input  start, abort, start_addr, burst_len, word_sel, mram_data_in,
        output mram_ce, mram_oe, mram_addr, ser_en, ser_load, ser_send_data,
               ser_word_sel, ser_data, bit_valid, busy, done, err
    );
endinterface

// File: rtl/mram_burst_read_ctrl.sv
// Reads a burst of MRAM words and sequences the downstream LSB-first serializer
// (address, load, then 16 or 8 back-to-back shift strobes per word).
module mram_burst_read_ctrl #(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    mram_burst_read_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ADDR, LOAD, SHIFT, DONE} state_t;

    localparam logic [4:0] LAT_LAST = 5'(RD_LAT - 1);

    state_t            r_state;
    state_t            w_nextState;
    logic [4:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_remaining;
    logic [1:0]        r_wordSel;
    logic [15:0]       r_serData;
    logic              r_bitValid;
    logic              r_err;
    logic              w_abort;
    logic              w_accept;
    logic              w_lastAddr;
    logic              w_lastShift;
    logic [4:0]        w_shiftLast;

    assign w_abort     = bus.abort && (r_state != IDLE);
    assign w_accept    = bus.start && (bus.word_sel != 2'b00) && (bus.burst_len != 8'd0);
    assign w_shiftLast = (r_wordSel == 2'b11) ? 5'd15 : 5'd7;
    assign w_lastAddr  = (r_cnt == LAT_LAST);
    assign w_lastShift = (r_cnt == w_shiftLast);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState       = r_state;
        bus.mram_ce       = 1'b0;
        bus.mram_oe       = 1'b0;
        bus.mram_addr     = '0;
        bus.ser_en        = 1'b0;
        bus.ser_load      = 1'b0;
        bus.ser_send_data = 1'b0;
        bus.ser_word_sel  = 2'b00;
        bus.ser_data      = 16'h0000;
        bus.busy          = 1'b0;
        bus.done          = 1'b0;
        bus.bit_valid     = r_bitValid;
        bus.err           = r_err;
        case (r_state)
            IDLE: begin
                if (bus.start && (bus.word_sel != 2'b00)) begin
                    if (bus.burst_len == 8'd0) begin
                        w_nextState = DONE;
                    end else begin
                        w_nextState = ADDR;
                    end
                end
            end
            ADDR: begin
                bus.mram_ce   = 1'b1;
                bus.mram_oe   = 1'b1;
                bus.mram_addr = r_addr;
                if (w_lastAddr) begin
                    w_nextState = LOAD;
                end
            end
            LOAD: begin
                bus.ser_load = 1'b1;
                w_nextState  = SHIFT;
            end
            SHIFT: begin
                bus.ser_send_data = 1'b1;
                if (w_lastShift) begin
                    if (r_remaining == 8'd1) begin
                        w_nextState = DONE;
                    end else begin
                        w_nextState = ADDR;
                    end
                end
            end
            DONE: begin
                bus.done    = 1'b1;
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
        // Captured word and mode are only presented while a burst owns the serializer.
        if (r_state != IDLE) begin
            bus.ser_en       = 1'b1;
            bus.busy         = 1'b1;
            bus.ser_word_sel = r_wordSel;
            bus.ser_data     = r_serData;
        end
        if (w_abort) begin
            w_nextState = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_addr      <= '0;
            r_remaining <= '0;
            r_wordSel   <= 2'b00;
            r_serData   <= 16'h0000;
            r_bitValid  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err      <= (r_state == IDLE) && bus.start && (bus.word_sel == 2'b00);
            r_bitValid <= (r_state == SHIFT) && !bus.abort;
            if (w_abort) begin
                r_cnt <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_cnt <= '0;
                        if (w_accept) begin
                            r_addr      <= bus.start_addr;
                            r_remaining <= bus.burst_len;
                            r_wordSel   <= bus.word_sel;
                        end
                    end
                    ADDR: begin
                        if (w_lastAddr) begin
                            r_serData <= bus.mram_data_in;
                            r_cnt     <= '0;
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                    SHIFT: begin
                        if (w_lastShift) begin
                            r_cnt       <= '0;
                            r_remaining <= r_remaining - 8'd1;
                            if (r_remaining != 8'd1) begin
                                r_addr <= r_addr + ADDR_W'(1);
                            end
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                    default: r_cnt <= '0;
                endcase
            end
        end
    end
endmodule

// File: doc/mram_burst_read_ctrl.md
# mram_burst_read_ctrl

Sequencer that sits directly upstream of the LSB-first parallel-to-serial burst stage. On a start request it reads a burst of consecutive 16-bit words from MRAM, captures each word, and drives the serializer's enable/load/send/word-select controls so that each word (full, lower byte or upper byte) is shifted out without gaps inside a word. It also reports a per-bit valid strobe aligned to the serializer's registered output, plus busy/done status to the host FSM.

## Interface
- ADDR_W, 10, MRAM word-address width
- RD_LAT, 2, cycles from address/CE/OE asserted to mram_data_in valid (legal range 1-15)
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-low
- start  in  1  one-cycle burst request, sampled only in IDLE
- abort  in  1  synchronous burst cancel
- start_addr  in  ADDR_W  first word address, captured on accepted start
- burst_len  in  8  word count, captured on accepted start; 0 = zero-length burst
- word_sel  in  2  11 full word, 01 lower byte, 10 upper byte; captured on accepted start
- mram_data_in  in  16  MRAM read data
- mram_ce  out  1  MRAM chip enable
- mram_oe  out  1  MRAM output enable
- mram_addr  out  ADDR_W  MRAM word address
- ser_en  out  1  serializer enable
- ser_load  out  1  serializer load strobe
- ser_send_data  out  1  serializer shift strobe
- ser_word_sel  out  2  captured word_sel
- ser_data  out  16  captured MRAM word
- bit_valid  out  1  serializer data_out holds a valid bit this cycle
- busy  out  1  burst in progress
- done  out  1  one-cycle burst-complete pulse
- err  out  1  one-cycle pulse: start rejected because word_sel = 00

## Operation
- States: IDLE, ADDR, LOAD, SHIFT, DONE.
- IDLE: start=1 and word_sel=00 -> err pulse next cycle, stay IDLE. start=1, burst_len=0 -> DONE (no MRAM access). Otherwise capture start_addr, burst_len into remaining, word_sel -> ADDR. start while not IDLE ignored.
- ADDR: mram_ce=mram_oe=1, mram_addr=current address, held RD_LAT cycles; on final ADDR edge ser_data <= mram_data_in -> LOAD.
- LOAD: ser_load=1 for exactly one cycle -> SHIFT. ser_load and ser_send_data never high in the same cycle.
- SHIFT: ser_send_data=1 for N consecutive cycles, N=16 (word_sel 11) or 8 (01/10). On last SHIFT edge: remaining decrements; remaining was 1 -> DONE, else address increments -> ADDR.
- Address arithmetic modulo 2^ADDR_W (all-ones wraps to 0).
- DONE: done=1 one cycle -> IDLE.
- busy=ser_en=1 in ADDR, LOAD, SHIFT, DONE.
- bit_valid = ser_send_data delayed one cycle.
- abort=1 in any non-IDLE state: next edge -> IDLE; ser_*, mram_ce/oe, bit_valid, busy low; no done. abort has priority over all transitions; ignored in IDLE.

## Timing
- Reset (rst=0 at edge): state IDLE; all outputs 0 (mram_addr, ser_data, ser_word_sel = 0); counters 0. Reset mid-burst behaves as abort plus clearing captured registers.
- Start accepted at edge E0: ADDR cycles 1..RD_LAT, LOAD cycle RD_LAT+1, SHIFT cycles RD_LAT+2..RD_LAT+1+N.
- Word period = RD_LAT+1+N cycles (19 for full word, RD_LAT=2; 11 for byte).
- First bit_valid cycle = RD_LAT+3 after E0; last bit_valid of final word coincides with DONE.
- Zero-length burst: done in cycle 1 after E0, no mram_ce.
- err pulse in cycle 1 after E0; busy stays 0.

## Test plan
- Reset: rst=0 two cycles with start=1 -> all outputs 0, no MRAM access, state IDLE after rst=1.
- Full-word burst: start_addr=0x010, burst_len=3, word_sel=11, MRAM model returns addr^0xA5A5, RD_LAT=2 -> addresses 0x010,0x011,0x012; 48 bit_valid cycles, serializer output LSB-first reconstructs 0xA5B5,0xA5B4,0xA5B7; done at cycle 58.
- Byte modes: burst_len=2, word_sel=10 then 01, word 0x3C96 -> 8 bits each, upper mode yields 0x3C, lower yields 0x96; word period 11 cycles.
- Wrap and boundaries: start_addr=0x3FF, burst_len=2 -> addresses 0x3FF then 0x000; burst_len=0 -> done in cycle 1, no CE; word_sel=00 -> err pulse, busy never set.
- Abort: abort in 5th SHIFT cycle of word 2 -> next cycle all ser_* and mram_* low, busy 0, no done; subsequent start runs normally.
- Start while busy: second start mid-burst ignored, captured address/length unchanged; reset asserted in LOAD -> IDLE with outputs 0 next cycle.
